wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter for the integer pipeline. It shares the single register-file write port between N_REQ execution units (for example ALU, MUL, DIV and LSU) using round-robin priority. For each write it generates the matching scoreboard clear (`clear_rd_addr`/`clear_rd_wr_en`), so the scoreboard busy bit for a destination register drops in the same cycle that the register-file write happens. It sits between the execute units and the register file / register scoreboard.

## Interface
Parameters:
- N_REQ, 4, number of writeback requesters; index 0 = highest priority out of reset
- XLEN, 32, data width
- N_REG, 32, number of architectural registers; address width AW = $clog2(N_REG)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  requester i holds a completed result
- req_rd_addr  in  N_REQ*AW  destination register per requester, packed, slice i at [i*AW +: AW]
- req_data  in  N_REQ*XLEN  result data per requester, packed, slice i at [i*XLEN +: XLEN]
- req_ready  out  N_REQ  one-hot-or-zero grant; transfer on req_valid[i] & req_ready[i]
- rf_wr_en  out  1  register-file write enable, registered
- rf_wr_addr  out  AW  register-file write address, registered
- rf_wr_data  out  XLEN  register-file write data, registered
- clear_rd_wr_en  out  1  scoreboard clear enable, registered
- clear_rd_addr  out  AW  scoreboard clear address, registered
- wb_busy  out  1  output stage holds a valid write this cycle (equals rf_wr_en | accepted x0 write)

## Operation
- The grant is combinational from req_valid and the round-robin pointer `rr_ptr` (AW_REQ = $clog2(N_REQ) bits).
- Search order: rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ. The first valid requester wins. At most one req_ready bit is high.
- req_ready[i] may be high only when req_valid[i] is high. There is no downstream backpressure, so one request is granted every cycle in which any req_valid is high.
- On a grant to requester g: rr_ptr <= (g+1) mod N_REQ. With no grant, rr_ptr holds.
- The output stage captures the granted rd_addr and data.
  - If rd_addr ≠ 0: rf_wr_en=1 and clear_rd_wr_en=1, with rf_wr_addr = clear_rd_addr = rd_addr.
  - If rd_addr == 0: the request is still granted (consumed), but rf_wr_en=0 and clear_rd_wr_en=0. wb_busy=1 for that cycle.
- Without a grant, the output-stage enables are 0 next cycle. Address and data registers hold their last values; do not reset them.
- pipe_flush is not an input. Flush squashing happens upstream. A granted result is always written, because it belongs to an older, committed instruction.
- If the scoreboard sets and clears the same register in the same cycle, the set wins; that rule lives in the scoreboard. The arbiter issues its clear unconditionally.
- Requesters must hold req_valid, req_rd_addr and req_data stable until granted. Dropping req_valid without a grant is illegal (bench assertion).

## Timing
- Reset values: rf_wr_en=0, clear_rd_wr_en=0, wb_busy=0, rr_ptr=0. req_ready=0 while rst=1.
- Latency: grant in cycle N → rf_wr_en and clear_rd_wr_en in cycle N+1. The register file writes at the end of N+1. The scoreboard bit reads clear from cycle N+2.
- Throughput: one writeback per cycle, sustained.
- Fairness: with all N_REQ valid continuously, each requester is granted exactly once per N_REQ cycles. Worst-case wait is N_REQ-1 cycles.
- Reset asserted mid-operation: the output enables are 0 in the cycle after rst is sampled. No grant is given during any rst=1 cycle. rr_ptr returns to 0.
- Single requester valid: it is granted every cycle regardless of rr_ptr.

## Test plan
- Reset, then only requester 2 valid, rd=5, data=0xDEADBEEF → req_ready=4'b0100 in the same cycle. Next cycle: rf_wr_en=1, rf_wr_addr=5, rf_wr_data=0xDEADBEEF, clear_rd_wr_en=1, clear_rd_addr=5. After that, rr_ptr=3.
- All 4 valid for 8 cycles (requesters hold and re-present new results) starting at rr_ptr=0 → grant order 0,1,2,3,0,1,2,3. Each requester is written exactly twice.
- Requester 1 valid with rd=0 → granted. Next cycle: rf_wr_en=0, clear_rd_wr_en=0, wb_busy=1.
- rr_ptr=3, requesters 0 and 2 valid → requester 0 granted (wrap-around), then requester 2 next cycle. After that, rr_ptr=3.
- rst asserted for one cycle while 3 requesters are valid and a write is pending → all req_ready=0 during reset, rf_wr_en=0 the following cycle, first grant after reset goes to the lowest valid index.
- With the scoreboard attached, set rd=7 at issue and complete it via the arbiter → rs1_hit for x7 is 1 until cycle N+1 and 0 from cycle N+2.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: round-robin share of the register-file write port,
// with a matching scoreboard clear issued alongside every real write.
module wb_arbiter #(
    parameter  int N_REQ  = 4,
    parameter  int XLEN   = 32,
    parameter  int N_REG  = 32,
    localparam int AW     = $clog2(N_REG),
    localparam int AW_REQ = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_rd_addr,
    input  logic [N_REQ*XLEN-1:0] req_data,
    output logic [N_REQ-1:0]      req_ready,
    output logic                  rf_wr_en,
    output logic [AW-1:0]         rf_wr_addr,
    output logic [XLEN-1:0]       rf_wr_data,
    output logic                  clear_rd_wr_en,
    output logic [AW-1:0]         clear_rd_addr,
    output logic                  wb_busy
);

    logic [AW_REQ-1:0] rr_ptr;
    logic [AW_REQ-1:0] gnt_idx;
    logic [AW_REQ-1:0] next_ptr;
    logic [AW_REQ:0]   pos;
    logic              found;
    logic [N_REQ-1:0]  grant;
    logic [AW-1:0]     gnt_rd;
    logic [XLEN-1:0]   gnt_data;

    // Scan from rr_ptr upward, wrapping; first valid requester wins.
    always_comb begin
        grant   = '0;
        found   = 1'b0;
        gnt_idx = '0;
        pos     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (AW_REQ+1)'(k);
            if (pos >= (AW_REQ+1)'(N_REQ))
                pos = pos - (AW_REQ+1)'(N_REQ);
            if (!found && !rst && req_valid[pos[AW_REQ-1:0]]) begin
                found        = 1'b1;
                gnt_idx      = pos[AW_REQ-1:0];
                grant[gnt_idx] = 1'b1;
            end
        end
    end

    assign req_ready = grant;
    assign gnt_rd    = req_rd_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];
    assign next_ptr  = (gnt_idx == AW_REQ'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr         <= '0;
            rf_wr_en       <= 1'b0;
            clear_rd_wr_en <= 1'b0;
            wb_busy        <= 1'b0;
        end else begin
            wb_busy        <= found;
            rf_wr_en       <= found && (gnt_rd != '0);
            clear_rd_wr_en <= found && (gnt_rd != '0);
            if (found)
                rr_ptr <= next_ptr;
        end
    end

    // Address/data carry no reset; they are qualified by the enables.
    always_ff @(posedge clk) begin
        if (found) begin
            rf_wr_addr    <= gnt_rd;
            clear_rd_addr <= gnt_rd;
            rf_wr_data    <= gnt_data;
        end
    end

endmodule
